// File: rtl/dense_acc_sat_if.sv
// Product-in / result-out handshake bundle for the dense-layer accumulator.
// The master side is the multiplier plus downstream consumer; the slave is the accumulator.
interface dense_acc_sat_if #(
  parameter int PROD_WIDTH = 20,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
);
  logic [BIAS_WIDTH-1:0] bias;
  logic [PROD_WIDTH-1:0] prod_data;
  logic                  prod_valid;
  logic                  prod_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_ovf;

  modport master (
    output bias, prod_data, prod_valid, out_ready,
    input  prod_ready, out_data, out_valid, out_ovf
  );

  modport slave (
    input  bias, prod_data, prod_valid, out_ready,
    output prod_ready, out_data, out_valid, out_ovf
  );
endinterface

// File: rtl/dense_acc_sat.sv
// Accumulates N_IN signed products plus a bias for one neuron, then rescales the sum
// with floor truncation, optional ReLU and saturation, and emits it over valid/ready.
module dense_acc_sat #(
  parameter int PROD_WIDTH = 20,
  parameter int ACC_WIDTH  = 25,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int N_IN       = 16,
  parameter int SHIFT      = 4,
  parameter int RELU       = 0
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  dense_acc_sat_if.slave s_if,
  output logic           busy
);
  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [CNT_W-1:0]            cnt_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] bias_ext_s;
  logic signed [ACC_WIDTH-1:0] term_s;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic [OUT_WIDTH-1:0]        out_data_r;
  logic                        out_ovf_r;
  logic                        accept_s;
  logic                        last_s;
  logic [OUT_WIDTH:0]          res_s;

  // Returns {ovf, data}: floor shift, optional ReLU clamp (never an overflow), then saturate.
  function automatic logic [OUT_WIDTH:0] rescale_fn(input logic signed [ACC_WIDTH-1:0] sum);
    logic signed [ACC_WIDTH-1:0] s;
    logic [OUT_WIDTH:0]          r;
    s = sum >>> SHIFT;
    if ((RELU != 0) && (s[ACC_WIDTH-1] == 1'b1)) begin
      s = {ACC_WIDTH{1'b0}};
    end else begin
      s = s;
    end
    if (s > OUT_MAX) begin
      r = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    end else if (s < OUT_MIN) begin
      r = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    end else begin
      r = {1'b0, s[OUT_WIDTH-1:0]};
    end
    return r;
  endfunction

  // Datapath: term 0 starts from the bias, later terms from the running sum.
  always_comb begin
    accept_s   = s_if.prod_valid & (state_r == S_ACC);
    last_s     = (cnt_r == CNT_LAST);
    bias_ext_s = {{(ACC_WIDTH-BIAS_WIDTH){s_if.bias[BIAS_WIDTH-1]}}, s_if.bias};
    term_s     = {{(ACC_WIDTH-PROD_WIDTH){s_if.prod_data[PROD_WIDTH-1]}}, s_if.prod_data};
    if (cnt_r == CNT_ZERO) begin
      sum_s = bias_ext_s + term_s;
    end else begin
      sum_s = acc_r + term_s;
    end
    res_s = rescale_fn(sum_s);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_ACC: begin
        if (accept_s && last_s) begin
          state_s = S_OUT;
        end else begin
          state_s = S_ACC;
        end
      end
      S_OUT: begin
        if (s_if.out_ready) begin
          state_s = S_ACC;
        end else begin
          state_s = S_OUT;
        end
      end
      default: state_s = S_ACC;
    endcase
  end

  // State, counter, accumulator and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r    <= S_ACC;
      cnt_r      <= CNT_ZERO;
      acc_r      <= {ACC_WIDTH{1'b0}};
      out_data_r <= {OUT_WIDTH{1'b0}};
      out_ovf_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        acc_r <= sum_s;
        if (last_s) begin
          cnt_r      <= CNT_ZERO;
          out_data_r <= res_s[OUT_WIDTH-1:0];
          out_ovf_r  <= res_s[OUT_WIDTH];
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign s_if.prod_ready = (state_r == S_ACC);
  assign s_if.out_valid  = (state_r == S_OUT);
  assign s_if.out_data   = out_data_r;
  assign s_if.out_ovf    = out_ovf_r;
  assign busy            = (cnt_r != CNT_ZERO) | (state_r == S_OUT);
endmodule

// File: tb/tb_dense_acc_sat.sv
// Directed bench for dense_acc_sat: two instances (RELU=0 and RELU=1) share one stimulus
// stream; a per-cycle reference model plus hand-computed literals check them.
module tb_dense_acc_sat;
  localparam int PW = 20, AW = 25, BW = 16, OW = 16, NI = 16, SH = 4;
  localparam longint OMAX = 32767, OMIN = -32768;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b1;
  logic busy0, busy1;
  int   vectors = 0, errors = 0, cyc = 0;

  dense_acc_sat_if #(.PROD_WIDTH(PW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) if0 ();
  dense_acc_sat_if #(.PROD_WIDTH(PW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) if1 ();

  assign if1.bias       = if0.bias;
  assign if1.prod_data  = if0.prod_data;
  assign if1.prod_valid = if0.prod_valid;
  assign if1.out_ready  = if0.out_ready;

  dense_acc_sat #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW),
                  .N_IN(NI), .SHIFT(SH), .RELU(0))
    dut0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_if(if0), .busy(busy0));
  dense_acc_sat #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW),
                  .N_IN(NI), .SHIFT(SH), .RELU(1))
    dut1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_if(if1), .busy(busy1));

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input logic [OW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampv(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  // Reference model: running sum per neuron, floor division, clamp.
  int     m_cnt = 0;
  bit     m_pend = 1'b0;
  longint m_sum = 0;
  longint m_exp0 = 0, m_exp1 = 0;
  bit     m_ovf0 = 1'b0, m_ovf1 = 1'b0;

  always @(posedge ap_clk or negedge ap_rst_n) begin : model
    longint total, q, r, dv;
    if (!ap_rst_n) begin
      m_cnt  <= 0;
      m_pend <= 1'b0;
      m_sum  <= 0;
    end else if (m_pend) begin
      if (if0.out_ready) m_pend <= 1'b0;
    end else if (if0.prod_valid) begin
      total = ((m_cnt == 0) ? longint'($signed(if0.bias)) : m_sum)
              + longint'($signed(if0.prod_data));
      if (m_cnt == NI - 1) begin
        dv = longint'(1) << SH;
        q  = total / dv;
        if ((total % dv) != 0 && total < 0) q = q - 1;
        r  = (q < 0) ? 0 : q;
        m_exp0 <= clampv(q);
        m_ovf0 <= (q > OMAX) || (q < OMIN);
        m_exp1 <= clampv(r);
        m_ovf1 <= (r > OMAX) || (r < OMIN);
        m_pend <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_sum <= total;
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int log_d[$];
  int log_c[$];

  // Per-cycle comparison against the model, plus a log of completed handshakes.
  always @(negedge ap_clk) begin
    chk("cmp_ready0", if0.prod_ready, !m_pend);
    chk("cmp_valid0", if0.out_valid, m_pend);
    chk("cmp_busy0", busy0, (m_cnt != 0) || m_pend);
    chk("cmp_valid1", if1.out_valid, m_pend);
    chk("cmp_busy1", busy1, (m_cnt != 0) || m_pend);
    if (m_pend) begin
      chk("cmp_data0", sgn(if0.out_data), m_exp0);
      chk("cmp_ovf0", if0.out_ovf, m_ovf0);
      chk("cmp_data1", sgn(if1.out_data), m_exp1);
      chk("cmp_ovf1", if1.out_ovf, m_ovf1);
    end
    if (if0.out_valid && if0.out_ready) begin
      log_d.push_back(int'(sgn(if0.out_data)));
      log_c.push_back(cyc);
    end
  end

  task automatic feed(input int b, input int first, input int rest, input int nterms, input bit gaps);
    for (int i = 0; i < nterms; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge ap_clk);
          if0.prod_valid = 1'b0;
          if0.prod_data  = 20'h5A5A5;
        end
      end
      @(negedge ap_clk);
      if0.prod_valid = 1'b1;
      if0.prod_data  = (i == 0) ? 20'(first) : 20'(rest);
      if0.bias       = (i == 0) ? 16'(b) : 16'h7FFF;
      if (i == NI - 1) chk("pre_last_valid", if0.out_valid, 0);
      @(posedge ap_clk);
    end
    @(negedge ap_clk);
    if0.prod_valid = 1'b0;
  endtask

  task automatic take(input int e0, input int o0, input int e1, input int o1, input int hold);
    chk("lat_valid", if0.out_valid, 1);
    chk("lit_data0", sgn(if0.out_data), e0);
    chk("lit_ovf0", if0.out_ovf, o0);
    chk("lit_data1", sgn(if1.out_data), e1);
    chk("lit_ovf1", if1.out_ovf, o1);
    for (int k = 0; k < hold; k++) begin
      if0.out_ready  = 1'b0;
      if0.prod_valid = 1'b1;
      if0.prod_data  = 20'h00123;
      @(negedge ap_clk);
      chk("hold_data", sgn(if0.out_data), e0);
      chk("hold_ready", if0.prod_ready, 0);
    end
    if0.prod_valid = 1'b0;
    if0.out_ready  = 1'b1;
    @(negedge ap_clk);
    if0.out_ready = 1'b0;
    chk("post_ready", if0.prod_ready, 1);
    chk("post_valid", if0.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb[3];
    int pp[3];
    bb = '{0, 160, -320};
    pp = '{16, 32, 48};
    if0.bias = 16'h0000;
    if0.prod_data = 20'h00000;
    if0.prod_valid = 1'b0;
    if0.out_ready = 1'b0;
    #1 ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    chk("rst_data", sgn(if0.out_data), 0);
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_ovf", if0.out_ovf, 0);
    chk("rst_busy", busy0, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rel_ready", if0.prod_ready, 1);

    feed(0, 16, 16, NI, 1'b0);             take(16, 0, 16, 0, 0);
    feed(100, 0, 0, NI, 1'b0);             take(6, 0, 6, 0, 0);
    feed(0, -1, 0, NI, 1'b0);              take(-1, 0, 0, 0, 0);
    feed(0, 524287, 524287, NI, 1'b0);     take(32767, 1, 32767, 1, 0);
    feed(0, -524288, -524288, NI, 1'b0);   take(-32768, 1, 0, 0, 0);
    feed(0, 16, 16, NI, 1'b1);             take(16, 0, 16, 0, 5);
    feed(37, -5, 3, NI, 1'b1);             take(4, 0, 4, 0, 0);
    feed(-100, -7, -7, NI, 1'b0);          take(-14, 0, 0, 0, 0);

    // Reset after 7 accepted terms: outputs clear immediately and the partial sum is lost.
    feed(500, 9, 9, 7, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_data", sgn(if0.out_data), 0);
    chk("arst_valid", if0.out_valid, 0);
    chk("arst_ovf", if0.out_ovf, 0);
    chk("arst_busy", busy0, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    feed(0, 1, 1, NI, 1'b0);               take(1, 0, 1, 0, 0);

    // Back-to-back: valid held high, bias and product changing per neuron.
    log_d.delete();
    log_c.delete();
    if0.out_ready = 1'b1;
    for (int c = 0; c < 3 * (NI + 1); c++) begin
      @(negedge ap_clk);
      if0.prod_valid = 1'b1;
      if0.bias       = 16'(bb[c / (NI + 1)]);
      if0.prod_data  = 20'(pp[c / (NI + 1)]);
    end
    @(negedge ap_clk);
    if0.prod_valid = 1'b0;
    repeat (3) @(negedge ap_clk);
    if0.out_ready = 1'b0;
    chk("b2b_count", log_d.size(), 3);
    if (log_d.size() >= 1) chk("b2b_d0", log_d[0], 16);
    if (log_d.size() >= 2) chk("b2b_d1", log_d[1], 42);
    if (log_d.size() >= 3) chk("b2b_d2", log_d[2], 28);
    if (log_c.size() >= 2) chk("b2b_gap01", log_c[1] - log_c[0], NI + 1);
    if (log_c.size() >= 3) chk("b2b_gap12", log_c[2] - log_c[1], NI + 1);

    repeat (2) @(negedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
